// File: rtl/countdown_timer.sv
// Loadable down-counter with start/stop control, one-cycle terminal-count pulse
// and optional automatic reload from the last loaded value.
module countdown_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             ld,
  input  logic             ce,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] C_ZERO = '0;
  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] r_rld;
  logic [WIDTH-1:0] w_rld_next;
  logic             r_tc;
  logic             w_tc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_q     <= C_ZERO;
      r_rld   <= C_ZERO;
      r_tc    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_q     <= w_q_next;
      r_rld   <= w_rld_next;
      r_tc    <= w_tc_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_q_next     = r_q;
    w_rld_next   = r_rld;
    w_tc_next    = 1'b0;

    if (ld) begin
      // A load overrides counting; it only decides whether we may be running.
      w_q_next   = d;
      w_rld_next = d;
      case (r_state)
        S_RUN:   if (d == C_ZERO) w_state_next = S_DONE;
        default: if (start && (d != C_ZERO)) w_state_next = S_RUN;
      endcase
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && (r_q != C_ZERO)) w_state_next = S_RUN;
        end
        S_DONE: begin
          if (start) begin
            w_q_next = r_rld;
            if (r_rld != C_ZERO) w_state_next = S_RUN;
          end
        end
        S_RUN: begin
          if (stop) begin
            w_state_next = S_IDLE;
          end else if (ce) begin
            if (r_q > C_ONE) begin
              w_q_next = r_q - C_ONE;
            end else if (r_q == C_ONE) begin
              // Terminal count: pulse tc together with the reload or final zero.
              w_tc_next = 1'b1;
              if (auto_reload && (r_rld != C_ZERO)) begin
                w_q_next = r_rld;
              end else begin
                w_q_next     = C_ZERO;
                w_state_next = S_DONE;
              end
            end
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  assign q    = r_q;
  assign tc   = r_tc;
  assign busy = (r_state == S_RUN);
  assign zero = (r_q == C_ZERO);

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios with literal
// expectations, then randomized traffic against a rule-level reference model.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d = 8'd0;
  logic       ld = 1'b0;
  logic       ce = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       auto_reload = 1'b0;
  logic [7:0] q;
  logic       tc;
  logic       busy;
  logic       zero;

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0 = idle, 1 = running, 2 = finished
  int m_q = 0;
  int m_rld = 0;
  int m_mode = 0;
  bit m_tc = 1'b0;

  countdown_timer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .d(d), .ld(ld), .ce(ce), .start(start),
    .stop(stop), .auto_reload(auto_reload), .q(q), .tc(tc), .busy(busy), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    m_tc = 1'b0;
    if (rst) begin
      m_q = 0; m_rld = 0; m_mode = 0;
    end else if (ld) begin
      m_q = d; m_rld = d;
      if (m_mode == 1) m_mode = (d == 0) ? 2 : 1;
      else if (start && d != 0) m_mode = 1;
    end else if (m_mode == 0) begin
      if (start && m_q != 0) m_mode = 1;
    end else if (m_mode == 2) begin
      if (start) begin
        m_q = m_rld;
        if (m_rld != 0) m_mode = 1;
      end
    end else if (stop) begin
      m_mode = 0;
    end else if (ce && m_q > 1) begin
      m_q = m_q - 1;
    end else if (ce && m_q == 1) begin
      m_tc = 1'b1;
      if (auto_reload && m_rld != 0) m_q = m_rld;
      else begin m_q = 0; m_mode = 2; end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    $display("t=%0t rst=%0b ld=%0b d=%0d start=%0b stop=%0b ce=%0b ar=%0b -> q=%0d tc=%0b busy=%0b zero=%0b",
             $time, rst, ld, d, start, stop, ce, auto_reload, q, tc, busy, zero);
  endtask

  task automatic clear_inputs();
    rst = 1'b0; ld = 1'b0; d = 8'd0; ce = 1'b0;
    start = 1'b0; stop = 1'b0; auto_reload = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1; ld = 1'b1; d = 8'd55; start = 1'b1; ce = 1'b1;
    tick();
    checks++;
    if ({q, tc, busy, zero} !== {8'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset q=%0d tc=%0b busy=%0b zero=%0b need q=0 tc=0 busy=0 zero=1", q, tc, busy, zero);
    end
    clear_inputs();
  endtask

  task automatic test_basic_countdown();
    int exp_q[4] = '{3, 2, 1, 0};
    do_reset();
    ld = 1'b1; d = 8'd3;
    tick();
    ld = 1'b0; start = 1'b1; ce = 1'b1;
    tick();
    checks++;
    if ({q, tc, busy} !== {8'd3, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL basic_start q=%0d tc=%0b busy=%0b need q=3 tc=0 busy=1", q, tc, busy);
    end
    start = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick();
      checks++;
      if ({q, tc, busy, zero} !== {8'(exp_q[i]), (i == 3), (i != 3), (i == 3)}) begin
        errors++;
        $display("FAIL basic_count step=%0d q=%0d tc=%0b busy=%0b zero=%0b need q=%0d tc=%0b busy=%0b",
                 i, q, tc, busy, zero, exp_q[i], (i == 3), (i != 3));
      end
    end
    tick();
    checks++;
    if ({q, tc, busy} !== {8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_after q=%0d tc=%0b busy=%0b need q=0 tc=0 busy=0", q, tc, busy);
    end
  endtask

  task automatic test_auto_reload();
    int exp_q[5] = '{2, 1, 2, 1, 2};
    do_reset();
    ld = 1'b1; d = 8'd2; auto_reload = 1'b1;
    tick();
    ld = 1'b0; start = 1'b1; ce = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 5; i++) begin
      tick();
      checks++;
      if ({q, tc, busy} !== {8'(exp_q[i]), (exp_q[i] == 2), 1'b1}) begin
        errors++;
        $display("FAIL auto_reload step=%0d q=%0d tc=%0b busy=%0b need q=%0d tc=%0b busy=1",
                 i, q, tc, busy, exp_q[i], (exp_q[i] == 2));
      end
    end
  endtask

  task automatic test_ce_stop();
    int exp_q[5] = '{5, 4, 4, 3, 3};
    do_reset();
    ld = 1'b1; d = 8'd5;
    tick();
    ld = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 5; i++) begin
      ce = (i % 2 == 1);
      tick();
      checks++;
      if ({q, tc, busy} !== {8'(exp_q[i]), 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL ce_gate step=%0d q=%0d tc=%0b busy=%0b need q=%0d tc=0 busy=1", i, q, tc, busy, exp_q[i]);
      end
    end
    stop = 1'b1; start = 1'b1; ce = 1'b1;
    tick();
    checks++;
    if ({q, tc, busy} !== {8'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL stop_wins q=%0d tc=%0b busy=%0b need q=3 tc=0 busy=0", q, tc, busy);
    end
    clear_inputs();
  endtask

  task automatic test_zero_restart();
    do_reset();
    ld = 1'b1; d = 8'd4;
    tick();
    ld = 1'b0; start = 1'b1; ce = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    ce = 1'b0; start = 1'b1;
    tick();
    checks++;
    if ({q, busy} !== {8'd4, 1'b1}) begin
      errors++;
      $display("FAIL done_restart q=%0d busy=%0b need q=4 busy=1", q, busy);
    end
    do_reset();
    start = 1'b1;
    tick();
    checks++;
    if ({q, busy, zero} !== {8'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL idle_zero_start q=%0d busy=%0b zero=%0b need q=0 busy=0 zero=1", q, busy, zero);
    end
    ld = 1'b1; d = 8'd9;
    tick();
    start = 1'b0; d = 8'd0; ce = 1'b1;
    tick();
    checks++;
    if ({q, tc, busy} !== {8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ld_zero_run q=%0d tc=%0b busy=%0b need q=0 tc=0 busy=0", q, tc, busy);
    end
    ld = 1'b0;
    tick();
    checks++;
    if (tc !== 1'b0) begin
      errors++;
      $display("FAIL ld_zero_no_tc tc=%0b need 0", tc);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    ld = 1'b1; d = 8'd1;
    tick();
    ld = 1'b0; start = 1'b1; ce = 1'b1;
    tick();
    start = 1'b0; rst = 1'b1;
    tick();
    checks++;
    if ({q, tc, busy} !== {8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_run q=%0d tc=%0b busy=%0b need q=0 tc=0 busy=0", q, tc, busy);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({tc, busy} !== {1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_run_after tc=%0b busy=%0b need tc=0 busy=0", tc, busy);
    end
    clear_inputs();
  endtask

  task automatic test_ld_in_run();
    do_reset();
    ld = 1'b1; d = 8'd200; start = 1'b1;
    tick();
    start = 1'b0; d = 8'd7; ce = 1'b1;
    tick();
    checks++;
    if ({q, busy} !== {8'd7, 1'b1}) begin
      errors++;
      $display("FAIL ld_in_run q=%0d busy=%0b need q=7 busy=1", q, busy);
    end
    ld = 1'b0; auto_reload = 1'b1;
    repeat (6) tick();
    tick();
    checks++;
    if ({q, tc, busy} !== {8'd7, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL ld_in_run_reload q=%0d tc=%0b busy=%0b need q=7 tc=1 busy=1", q, tc, busy);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst         = ($urandom_range(0, 99) < 2);
      ld          = ($urandom_range(0, 99) < 10);
      d           = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
      start       = ($urandom_range(0, 99) < 25);
      stop        = ($urandom_range(0, 99) < 8);
      ce          = ($urandom_range(0, 99) < 70);
      auto_reload = ($urandom_range(0, 1) == 1);
      tick();
      checks++;
      if ({q, tc, busy, zero} !== {8'(m_q), m_tc, (m_mode == 1), (m_q == 0)}) begin
        errors++;
        $display("FAIL random cycle=%0d q=%0d tc=%0b busy=%0b zero=%0b need q=%0d tc=%0b busy=%0b zero=%0b",
                 i, q, tc, busy, zero, m_q, m_tc, (m_mode == 1), (m_q == 0));
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_basic_countdown();
    test_auto_reload();
    test_ce_stop();
    test_zero_restart();
    test_reset_mid_run();
    test_ld_in_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
